// File: rtl/cc_unit.sv
// cc_unit: execute-stage ALU with speculative condition-code tracking.
// A flag-setting ALU operation is captured into a single pending slot.
// The slot is later retired into the committed flags (commit) or dropped
// (squash). Flag layout: cf[0]=OF, cf[1]=ZF, cf[2]=SF.
// Optional feature macro: CC_BYPASS_EN. When it is defined, a committing
// cycle presents the pending flags on cf combinationally, before the edge.
module cc_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             set_cc,
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  input  logic             commit,
  input  logic             squash,
  output logic [2:0]       cf,
  output logic             pending
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [2:0] RESET_FLAGS = 3'b010;

  state_t     state;
  state_t     next_state;
  logic [2:0] new_flags;
  logic [2:0] pend_flags;
  logic [2:0] cf_reg;
  logic       capture;
  logic       commit_now;
  logic       of_bit;
  logic       zf_bit;
  logic       sf_bit;

  // ALU result and the flags it would produce if captured
  always_comb begin
    alu_out = '0;
    of_bit  = 1'b0;
    case (alu_fun)
      2'd0: begin
        alu_out = alu_b + alu_a;
        of_bit  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      2'd1: begin
        alu_out = alu_b - alu_a;
        of_bit  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != alu_b[WIDTH-1]);
      end
      2'd2: alu_out = alu_b & alu_a;
      default: alu_out = alu_b ^ alu_a;
    endcase
    zf_bit    = (alu_out == '0);
    sf_bit    = alu_out[WIDTH-1];
    new_flags = {sf_bit, zf_bit, of_bit};
  end

  // State register; reset drops any pending update without committing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: squash beats commit, and a capture alongside a commit
  // refills the slot so the unit stays in PEND
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (capture) next_state = PEND;
      end
      PEND: begin
        if (squash) begin
          next_state = IDLE;
        end else if (commit) begin
          next_state = capture ? PEND : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs and handshake qualifiers; the slot only frees up when it is
  // being committed in the same cycle, so a squash cycle never accepts
  always_comb begin
    in_ready   = (state == IDLE) || (commit && !squash);
    pending    = (state == PEND);
    capture    = in_valid && set_cc && in_ready;
    commit_now = (state == PEND) && commit && !squash;
`ifdef CC_BYPASS_EN
    cf = commit_now ? pend_flags : cf_reg;
`else
    cf = cf_reg;
`endif
  end

  // Pending slot and committed flags; the commit reads the old slot value
  // even when a new capture overwrites the slot at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flags <= RESET_FLAGS;
      cf_reg     <= RESET_FLAGS;
    end else begin
      if (capture)    pend_flags <= new_flags;
      if (commit_now) cf_reg     <= pend_flags;
    end
  end

endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: directed-vector bench for cc_unit with hand-computed flags.
module tb_cc_unit;

  localparam int WIDTH = 64;

`ifdef CC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             set_cc;
  logic [1:0]       alu_fun;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             commit;
  logic             squash;
  logic [2:0]       cf;
  logic             pending;

  int total;
  int bad;

  cc_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .set_cc   (set_cc),
    .alu_fun  (alu_fun),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .commit   (commit),
    .squash   (squash),
    .cf       (cf),
    .pending  (pending)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive one cycle's inputs and let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic sc, input logic [1:0] fun,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic cm, input logic sq);
    in_valid = v;
    set_cc   = sc;
    alu_fun  = fun;
    alu_a    = a;
    alu_b    = b;
    commit   = cm;
    squash   = sq;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 0, 0);
    #1;
    checkOutput("ready_in_reset", {63'd0, in_ready}, 64'd1);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_cf", {61'd0, cf}, 64'd2);
    checkOutput("reset_pending", {63'd0, pending}, 64'd0);
    checkOutput("reset_ready", {63'd0, in_ready}, 64'd1);

    // add overflow: flags SF=1 ZF=0 OF=1
    applyStimulus(1, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    checkOutput("add_out", alu_out, 64'h8000_0000_0000_0000);
    tick();
    checkOutput("add_pending", {63'd0, pending}, 64'd1);
    checkOutput("add_cf_precommit", {61'd0, cf}, 64'd2);
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    checkOutput("add_cf_commit_cycle", {61'd0, cf}, BYPASS ? 64'd5 : 64'd2);
    tick();
    checkOutput("add_cf", {61'd0, cf}, 64'd5);
    checkOutput("add_pending_clr", {63'd0, pending}, 64'd0);

    // non-flag op and commit while idle: nothing changes
    applyStimulus(1, 0, 2'd1, 64'd3, 64'd9, 1, 0);
    checkOutput("nocc_out", alu_out, 64'd6);
    tick();
    checkOutput("nocc_pending", {63'd0, pending}, 64'd0);
    checkOutput("nocc_cf", {61'd0, cf}, 64'd5);

    // sub 5-5: zero
    applyStimulus(1, 1, 2'd1, 64'd5, 64'd5, 0, 0);
    checkOutput("sub_out", alu_out, 64'd0);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("sub_cf", {61'd0, cf}, 64'd2);

    // capture 0-1 (SF=1), then commit+squash together: squash wins
    applyStimulus(1, 1, 2'd1, 64'd1, 64'd0, 0, 0);
    checkOutput("neg_out", alu_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 1);
    checkOutput("cs_ready", {63'd0, in_ready}, 64'd0);
    tick();
    checkOutput("cs_pending", {63'd0, pending}, 64'd0);
    checkOutput("cs_cf", {61'd0, cf}, 64'd2);

    // same op, committed this time
    applyStimulus(1, 1, 2'd1, 64'd1, 64'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("neg_cf", {61'd0, cf}, 64'd4);

    // and 0xF0 & 0x0F: zero, OF clear
    applyStimulus(1, 1, 2'd2, 64'hF0, 64'h0F, 0, 0);
    checkOutput("and_out", alu_out, 64'd0);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("and_cf", {61'd0, cf}, 64'd2);

    // xor 1^0 captured (flags 000), then capture add 0+0 (flags 010) with commit
    applyStimulus(1, 1, 2'd3, 64'd1, 64'd0, 0, 0);
    checkOutput("xor_out", alu_out, 64'd1);
    tick();
    checkOutput("xor_pending", {63'd0, pending}, 64'd1);
    applyStimulus(1, 1, 2'd0, 64'd0, 64'd0, 1, 0);
    checkOutput("bb_ready", {63'd0, in_ready}, 64'd1);
    tick();
    checkOutput("bb_cf", {61'd0, cf}, 64'd0);
    checkOutput("bb_pending", {63'd0, pending}, 64'd1);
    // blocked capture attempt must not overwrite the slot
    applyStimulus(1, 1, 2'd1, 64'd1, 64'd0, 0, 0);
    checkOutput("blk_ready", {63'd0, in_ready}, 64'd0);
    tick();
    checkOutput("blk_pending", {63'd0, pending}, 64'd1);
    checkOutput("blk_cf", {61'd0, cf}, 64'd0);
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("blk_commit_cf", {61'd0, cf}, 64'd2);
    checkOutput("blk_commit_pending", {63'd0, pending}, 64'd0);

    // squash alone in PEND
    applyStimulus(1, 1, 2'd1, 64'd1, 64'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 0, 1);
    tick();
    checkOutput("sq_pending", {63'd0, pending}, 64'd0);
    checkOutput("sq_cf", {61'd0, cf}, 64'd2);
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("idle_commit_cf", {61'd0, cf}, 64'd2);

    // reset between edges during a commit cycle
    applyStimulus(1, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    checkOutput("rst_commit_cycle_cf", {61'd0, cf}, BYPASS ? 64'd5 : 64'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cf", {61'd0, cf}, 64'd2);
    checkOutput("midrst_pending", {63'd0, pending}, 64'd0);
    checkOutput("midrst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 2'd3, 64'd1, 64'd0, 0, 0);
    tick();
    checkOutput("postrst_pending", {63'd0, pending}, 64'd1);
    checkOutput("postrst_cf", {61'd0, cf}, 64'd2);
    applyStimulus(0, 0, 2'd0, 64'd0, 64'd0, 1, 0);
    tick();
    checkOutput("postrst_commit_cf", {61'd0, cf}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_unit.md
CC_UNIT -- requirements
Module: cc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  execute stage presents an ALU operation.
REQ-005 SHALL have port in_ready  output  1  unit can accept a capture this cycle.
REQ-006 SHALL have port set_cc  input  1  presented operation updates condition codes.
REQ-007 SHALL have port alu_fun  input  2  0=add (b+a), 1=sub (b-a), 2=and, 3=xor.
REQ-008 SHALL have port alu_a  input  WIDTH  operand A (valA).
REQ-009 SHALL have port alu_b  input  WIDTH  operand B (valB).
REQ-010 SHALL have port alu_out  output  WIDTH  combinational ALU result for the presented operands.
REQ-011 SHALL have port commit  input  1  retire the pending flag update.
REQ-012 SHALL have port squash  input  1  discard the pending flag update (mispredict/exception).
REQ-013 SHALL have port cf  output  3  committed flags: cf[0]=OF, cf[1]=ZF, cf[2]=SF.
REQ-014 SHALL have port pending  output  1  high while a captured update awaits commit/squash.

Function
REQ-015 SHALL compute alu_out mod 2^WIDTH per alu_fun; sub is alu_b minus alu_a.
REQ-016 SHALL derive ZF = (alu_out == 0) and SF = alu_out[WIDTH-1].
REQ-017 SHALL derive OF for add as a[MSB]==b[MSB] && out[MSB]!=a[MSB]; for sub as a[MSB]!=b[MSB] && out[MSB]!=b[MSB]; OF=0 for and/xor.
REQ-018 SHALL implement two states: IDLE (no pending update) and PEND (one captured update held).
REQ-019 SHALL capture derived flags into the pending register on an edge where in_valid && set_cc && in_ready; operations with set_cc=0 are accepted without changing state.
REQ-020 SHALL drive in_ready=1 in IDLE and in PEND only when commit=1 and squash=0 in that cycle.
REQ-021 In PEND, commit=1 and squash=0 SHALL copy the pending flags to cf at that edge and go to IDLE, unless a capture occurs at the same edge, in which case the state stays PEND holding the new flags.
REQ-022 In PEND, squash=1 SHALL discard the pending flags, leave cf unchanged, and go to IDLE; squash SHALL take priority over commit in the same cycle.
REQ-023 In IDLE, commit and squash SHALL be ignored.
REQ-024 The pending output SHALL equal (state==PEND); cf SHALL change only on a commit edge (subject to REQ-029).
REQ-025 Captures SHALL NOT occur while in_ready=0; the operation is held upstream, with no loss and no overwrite.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, pending=0, and cf=3'b010 (ZF=1, SF=0, OF=0), independent of clk.
REQ-027 Reset during PEND SHALL drop the pending update with no commit.
REQ-028 in_ready SHALL read 1 while rst is high; after rst deasserts, the first capture SHALL be possible at the first rising edge.

Configuration
REQ-029 Macro CC_BYPASS_EN: when defined, cf SHALL combinationally present the pending flags during any cycle with state=PEND, commit=1, squash=0 (zero-latency commit forward); when undefined, cf SHALL reflect a commit only after the committing edge.

Verification
REQ-030 Reset, then no activity -> cf=3'b010, pending=0, in_ready=1.
REQ-031 WIDTH=64, add a=0x7FFFFFFFFFFFFFFF, b=1, set_cc, then commit -> alu_out=0x8000000000000000, cf=3'b101 (SF=1, OF=1).
REQ-032 sub a=5, b=5, set_cc, then commit -> alu_out=0, cf=3'b010; and with a=0xF0, b=0x0F -> ZF=1, OF=0.
REQ-033 Capture in IDLE, then same-cycle commit and squash -> cf unchanged, pending=0.
REQ-034 Capture xor a=1, b=0 (pending=1); next cycle a new capture with commit=1 -> cf=3'b000 after that edge and pending stays 1; a capture attempt without commit -> in_ready=0 and no change.
REQ-035 rst asserted mid-PEND between edges -> cf=3'b010 and pending=0 immediately; with CC_BYPASS_EN, check the commit-cycle cf equals the pending flags before the edge.
